xmpl_dsp_msf_drv: RTL
=====================

// Module: xmpl_dsp_msf_drv
// PURPOSE
//   Initiator-side driver for the xmpl_dsp_msf operand/result interface. Accepts operand commands
//   over valid/ready, fires the one-cycle MSF start strobe with the operand held stable, and waits
//   for MSF done/error status. Returns the 32-bit result over valid/ready; guards with a timeout.
//   Sits between the DSP control sequencer and one xmpl_dsp_msf instance.
// PARAMETERS
//   OPND_W       12    operand width (msf_b_o, cmd_operand_i)
//   DATA_W       32    result/status width (msf_c_i, msf_status_i, rsp_data_o)
//   TIMEOUT_CYC  1024  max WAIT cycles before timeout; legal range 2..65535
//   DONE_BIT     0     msf_status_i bit meaning "result valid"
//   ERR_BIT      1     msf_status_i bit meaning "operation failed"
// PORTS
//   clk_i          in   1       clock, single clock domain
//   reset_i        in   1       asynchronous, active-high reset
//   cmd_valid_i    in   1       operand command valid
//   cmd_ready_o    out  1       driver can accept a command
//   cmd_operand_i  in   OPND_W  operand for the MSF
//   msf_a_o        out  1       MSF start strobe, exactly one cycle per command
//   msf_b_o        out  OPND_W  operand to MSF, held from accept until next accept
//   msf_c_i        in   DATA_W  MSF result
//   msf_status_i   in   DATA_W  MSF status word
//   rsp_valid_o    out  1       response valid
//   rsp_ready_i    in   1       response consumer ready
//   rsp_data_o     out  DATA_W  captured msf_c_i; 0 on timeout
//   rsp_err_o      out  1       MSF ERR_BIT set at done, or timeout
//   rsp_tmo_o      out  1       response caused by timeout
//   busy_o         out  1       state != IDLE
//   err_cnt_o      out  8       saturating count of responses with rsp_err_o=1
// BEHAVIOUR
//   Reset (async assert, sync-released use): state=IDLE; every output 0 except cmd_ready_o=1.
//   FSM IDLE->ISSUE->WAIT->RESP->IDLE:
//   - IDLE: cmd_ready_o=1. On cmd_valid_i&cmd_ready_o, register operand into msf_b_o -> ISSUE.
//   - ISSUE: msf_a_o=1 for this cycle only; clear timer -> WAIT.
//   - WAIT: sample msf_status_i each cycle. DONE_BIT=1: capture msf_c_i into rsp_data_o,
//     rsp_err_o=status[ERR_BIT], rsp_tmo_o=0 -> RESP. Else timer++; when timer==TIMEOUT_CYC-1:
//     rsp_data_o=0, rsp_err_o=1, rsp_tmo_o=1 -> RESP.
//   - RESP: rsp_valid_o=1, data/flags stable until rsp_ready_i=1; on handshake -> IDLE.
//   Latency: accept at cycle N, msf_a_o at N+1, earliest done sample N+2, rsp_valid_o at N+3.
//   Throughput: one command in flight; cmd_ready_o=0 from accept until cycle after rsp handshake.
//   Boundaries:
//   - Done asserted during ISSUE or IDLE is ignored (status sampled only in WAIT).
//   - Done and timeout in the same cycle: done wins, rsp_tmo_o=0.
//   - rsp_ready_i held high: response lasts exactly one cycle; no back-to-back accept in that cycle.
//   - err_cnt_o increments on RESP handshake when rsp_err_o=1; saturates at 255, never wraps.
//   - Reset mid-operation: immediate return to IDLE, pending response discarded, msf_a_o=0.
//   - msf_b_o is not cleared after response; it changes only on accept or reset.
//   - Timer width = $clog2(TIMEOUT_CYC); no wrap possible before timeout compare.
// STRUCTURE
//   xmpl_dsp_msf_pkg: state enum (IDLE/ISSUE/WAIT/RESP), DONE_BIT/ERR_BIT defaults,
//     OPND_W/DATA_W defaults, ERR_CNT_W=8 constant.
//   One sub-module: xmpl_dsp_msf_tmr (clear/enable timeout counter, expired flag at
//     TIMEOUT_CYC-1). FSM, capture registers and err counter stay in xmpl_dsp_msf_drv.
// TESTING
//   1 Basic: operand 12'h5A3, status done after 3 WAIT cycles with c=32'hDEAD_BEEF -> one
//     msf_a_o pulse with msf_b_o=12'h5A3, rsp_data_o=32'hDEAD_BEEF, err=0, tmo=0.
//   2 Timeout: TIMEOUT_CYC=8, status never done -> rsp_valid_o 8 WAIT cycles after strobe,
//     data=0, err=1, tmo=1; err_cnt_o=1 after handshake.
//   3 MSF error: done with status=32'h3 -> rsp_err_o=1, rsp_tmo_o=0, data captured.
//   4 Backpressure: rsp_ready_i low 5 cycles -> rsp held stable, cmd_ready_o=0 throughout,
//     new cmd_valid_i not accepted until cycle after handshake.
//   5 Race/early done: done high during ISSUE ignored; done on timeout cycle -> tmo=0.
//   6 Reset mid-WAIT and err_cnt saturation: reset -> IDLE, outputs 0, cmd_ready_o=1;
//     300 timeouts -> err_cnt_o=255.

Source files
------------

// File: rtl/xmpl_dsp_msf_pkg.sv
// Shared constants and state encoding for the xmpl_dsp_msf initiator-side driver.
package xmpl_dsp_msf_pkg;

    localparam int OPND_W_DEF   = 12;
    localparam int DATA_W_DEF   = 32;
    localparam int DONE_BIT_DEF = 0;
    localparam int ERR_BIT_DEF  = 1;
    localparam int ERR_CNT_W    = 8;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    // The error count holds at its maximum instead of wrapping back to zero.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/xmpl_dsp_msf_tmr.sv
// Timeout counter for the WAIT phase: cleared on issue, counts enabled cycles,
// flags expiry once the count reaches TIMEOUT_CYC-1.
module xmpl_dsp_msf_tmr #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
        end else if (clr_i) begin
            count <= '0;
        end else if (en_i && !expired_o) begin
            count <= count + TMR_W'(1);
        end
    end

    assign expired_o = (count == LAST);

endmodule

// File: rtl/xmpl_dsp_msf_drv.sv
// Initiator-side driver for one xmpl_dsp_msf: accepts an operand, strobes the MSF,
// waits for done/error (or times out) and returns the result over valid/ready.
module xmpl_dsp_msf_drv
    import xmpl_dsp_msf_pkg::*;
#(
    parameter int OPND_W      = OPND_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 1024,
    parameter int DONE_BIT    = DONE_BIT_DEF,
    parameter int ERR_BIT     = ERR_BIT_DEF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [OPND_W-1:0]    cmd_operand_i,
    output logic                 msf_a_o,
    output logic [OPND_W-1:0]    msf_b_o,
    input  logic [DATA_W-1:0]    msf_c_i,
    input  logic [DATA_W-1:0]    msf_status_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATA_W-1:0]    rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 rsp_tmo_o,
    output logic                 busy_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    state_t state;
    state_t state_nxt;
    logic   done;
    logic   tmr_expired;
    logic   status_unused;

    assign done          = msf_status_i[DONE_BIT];
    assign status_unused = ^msf_status_i;

    xmpl_dsp_msf_tmr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clr_i     (state == ST_ISSUE),
        .en_i      ((state == ST_WAIT) && !done),
        .expired_o (tmr_expired)
    );

    // NOTE: the default assignment up front keeps this block purely combinational (no latches).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cmd_valid_i) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (done || tmr_expired) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready_i) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= ST_IDLE;
            msf_b_o    <= '0;
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b0;
            rsp_tmo_o  <= 1'b0;
            err_cnt_o  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && cmd_valid_i) begin
                msf_b_o <= cmd_operand_i;
            end
            // Done takes priority over a timeout expiring in the same cycle.
            if (state == ST_WAIT) begin
                if (done) begin
                    rsp_data_o <= msf_c_i;
                    rsp_err_o  <= msf_status_i[ERR_BIT];
                    rsp_tmo_o  <= 1'b0;
                end else if (tmr_expired) begin
                    rsp_data_o <= '0;
                    rsp_err_o  <= 1'b1;
                    rsp_tmo_o  <= 1'b1;
                end
            end
            if (state == ST_RESP && rsp_ready_i && rsp_err_o) begin
                err_cnt_o <= sat_inc(err_cnt_o);
            end
        end
    end

    assign cmd_ready_o = (state == ST_IDLE);
    assign msf_a_o     = (state == ST_ISSUE);
    assign rsp_valid_o = (state == ST_RESP);
    assign busy_o      = (state != ST_IDLE);

endmodule
